// File: rtl/serial_add.sv
// -----------------------------------------------------------------------------
// serial_add
//
// Multi-cycle unsigned adder. It adds two WIDTH-bit operands and a carry-in,
// DIGIT bits per clock, using one DIGIT-wide adder slice over N = WIDTH/DIGIT
// cycles. A start/done handshake connects it to its controller.
//
// Parameters
//   WIDTH  operand/sum width in bits (>= 1)
//   DIGIT  bits added per cycle (1..WIDTH, must divide WIDTH)
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request, sampled only while not busy
//   a, b   in   WIDTH  operands, sampled with start
//   ci     in   1      carry-in, sampled with start
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse when s/co (and ov) are updated
//   s      out  WIDTH  sum, held until the next completion
//   co     out  1      carry-out, held until the next completion
//   ov     out  1      two's-complement overflow (only with SERIAL_ADD_OVF_EN)
//
// Build option
//   SERIAL_ADD_OVF_EN : when defined, adds the ov output and its logic.
// -----------------------------------------------------------------------------
module serial_add #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ov
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  // Partial-sum register only needs the digits that precede the last one;
  // the last digit goes straight into s on the completing edge.
  localparam int SH_W  = (N > 1) ? (WIDTH - DIGIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Reject illegal parameter combinations at elaboration
  if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("serial_add: illegal WIDTH=%0d / DIGIT=%0d", WIDTH, DIGIT);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One DIGIT-wide adder slice: returns {carry_out, digit_sum}
  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             cin);
    digit_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  endfunction

`ifdef SERIAL_ADD_OVF_EN
  // Carry into the MSB is recovered as x ^ y ^ sum at that bit position;
  // overflow is that carry XOR the carry out of the MSB.
  function automatic logic msb_overflow(input logic x_msb,
                                        input logic y_msb,
                                        input logic sum_msb,
                                        input logic cout);
    msb_overflow = cout ^ (x_msb ^ y_msb ^ sum_msb);
  endfunction
`endif

  state_t             state_r,     state_nxt_s;
  logic [WIDTH-1:0]   a_sh_r,      a_sh_nxt_s;
  logic [WIDTH-1:0]   b_sh_r,      b_sh_nxt_s;
  logic [SH_W-1:0]    s_sh_r,      s_sh_nxt_s;
  logic               carry_r,     carry_nxt_s;
  logic [CNT_W-1:0]   cnt_r,       cnt_nxt_s;
  logic               busy_nxt_s;
  logic               done_nxt_s;
  logic [WIDTH-1:0]   s_nxt_s;
  logic               co_nxt_s;
`ifdef SERIAL_ADD_OVF_EN
  logic               ov_nxt_s;
`endif

  logic [DIGIT:0]     sum_dig_s;
  logic [WIDTH-1:0]   s_full_s;

  // Current digit sum from the low digits of the operand shift registers
  assign sum_dig_s = digit_add(a_sh_r[DIGIT-1:0], b_sh_r[DIGIT-1:0], carry_r);

  // Partial sum with the new digit entering from the MSB end
  if (N > 1) begin : g_shift
    assign s_full_s = {sum_dig_s[DIGIT-1:0], s_sh_r};
  end else begin : g_single
    assign s_full_s = sum_dig_s[DIGIT-1:0];
  end

  // Next-state and next-datapath logic for the IDLE/RUN/DONE controller
  always_comb begin
    state_nxt_s = state_r;
    a_sh_nxt_s  = a_sh_r;
    b_sh_nxt_s  = b_sh_r;
    s_sh_nxt_s  = s_sh_r;
    carry_nxt_s = carry_r;
    cnt_nxt_s   = cnt_r;
    busy_nxt_s  = busy;
    done_nxt_s  = 1'b0;
    s_nxt_s     = s;
    co_nxt_s    = co;
`ifdef SERIAL_ADD_OVF_EN
    ov_nxt_s    = ov;
`endif

    case (state_r)
      // DONE accepts a new request exactly like IDLE, giving back-to-back ops
      IDLE, DONE: begin
        if (start) begin
          a_sh_nxt_s  = a;
          b_sh_nxt_s  = b;
          s_sh_nxt_s  = {SH_W{1'b0}};
          carry_nxt_s = ci;
          cnt_nxt_s   = {CNT_W{1'b0}};
          busy_nxt_s  = 1'b1;
          state_nxt_s = RUN;
        end else begin
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end
      end

      RUN: begin
        a_sh_nxt_s  = a_sh_r >> DIGIT;
        b_sh_nxt_s  = b_sh_r >> DIGIT;
        s_sh_nxt_s  = s_full_s[WIDTH-1 -: SH_W];
        carry_nxt_s = sum_dig_s[DIGIT];
        cnt_nxt_s   = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_LAST) begin
          // Completing edge: publish the result, the only time s/co move
          s_nxt_s     = s_full_s;
          co_nxt_s    = sum_dig_s[DIGIT];
`ifdef SERIAL_ADD_OVF_EN
          ov_nxt_s    = msb_overflow(a_sh_r[DIGIT-1], b_sh_r[DIGIT-1],
                                     sum_dig_s[DIGIT-1], sum_dig_s[DIGIT]);
`endif
          cnt_nxt_s   = {CNT_W{1'b0}};
          done_nxt_s  = 1'b1;
          busy_nxt_s  = 1'b0;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end

      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset discards any partial result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      s_sh_r  <= {SH_W{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= {WIDTH{1'b0}};
      co      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ov      <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      a_sh_r  <= a_sh_nxt_s;
      b_sh_r  <= b_sh_nxt_s;
      s_sh_r  <= s_sh_nxt_s;
      carry_r <= carry_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy    <= busy_nxt_s;
      done    <= done_nxt_s;
      s       <= s_nxt_s;
      co      <= co_nxt_s;
`ifdef SERIAL_ADD_OVF_EN
      ov      <= ov_nxt_s;
`endif
    end
  end

endmodule
